// File: rtl/sorteio_classes_if.sv
// Bus between the control unit and the role-draw block: start/seed, read port, status.
interface sorteio_classes_if;
    logic       inicia;
    logic [7:0] seed;
    logic [2:0] jogador;
    logic       mostra;
    logic [1:0] classe;
    logic       classe_valida;
    logic       pronto;
    logic       ocupado;
    logic [2:0] db_estado;

    modport master (
        output inicia, seed, jogador, mostra,
        input  classe, classe_valida, pronto, ocupado, db_estado
    );

    modport slave (
        input  inicia, seed, jogador, mostra,
        output classe, classe_valida, pronto, ocupado, db_estado
    );
endinterface

// File: rtl/sorteio_classes.sv
// Draws player roles (lobo, vidente, medico, aldeao) into an 8-entry table using an LFSR.
//
// state    | meaning
// OCIOSO   | idle, no table held
// LIMPA    | clear table, flags and role counter
// SORTEIA  | step the LFSR to produce a candidate
// VERIFICA | place role(k) on candidate if free, else retry
// PRONTO   | complete table held and readable
module sorteio_classes #(
    parameter int N_LOBOS = 2
) (
    input logic              clock,
    input logic              reset,
    sorteio_classes_if.slave bus
);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        LIMPA    = 3'd1,
        SORTEIA  = 3'd2,
        VERIFICA = 3'd3,
        PRONTO   = 3'd4
    } estado_t;

    localparam logic [7:0] LFSR_INIT = 8'hA5;

    estado_t    estado_q, estado_d;
    logic [1:0] role_q [8];
    logic [1:0] role_d [8];
    logic [7:0] ocup_q, ocup_d;
    logic [2:0] k_q, k_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] cand;

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [1:0] role_of(input logic [2:0] k);
        if (k < 3'(N_LOBOS))       return 2'b01;
        else if (k == 3'(N_LOBOS)) return 2'b10;
        else                       return 2'b11;
    endfunction

    assign cand = lfsr_q[2:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            for (int i = 0; i < 8; i++) role_q[i] <= 2'b00;
            ocup_q   <= '0;
            k_q      <= '0;
            lfsr_q   <= LFSR_INIT;
        end else begin
            estado_q <= estado_d;
            role_q   <= role_d;
            ocup_q   <= ocup_d;
            k_q      <= k_d;
            lfsr_q   <= lfsr_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        role_d   = role_q;
        ocup_d   = ocup_q;
        k_d      = k_q;
        lfsr_d   = lfsr_q;
        case (estado_q)
            OCIOSO, PRONTO: begin
                if (bus.inicia) begin
                    estado_d = LIMPA;
                    lfsr_d   = (bus.seed == 8'h00) ? LFSR_INIT : bus.seed;
                end
            end
            LIMPA: begin
                for (int i = 0; i < 8; i++) role_d[i] = 2'b00;
                ocup_d   = '0;
                k_d      = '0;
                estado_d = SORTEIA;
            end
            SORTEIA: begin
                lfsr_d   = lfsr_step(lfsr_q);
                estado_d = VERIFICA;
            end
            VERIFICA: begin
                if (ocup_q[cand]) begin
                    estado_d = SORTEIA;
                end else begin
                    role_d[cand] = role_of(k_q);
                    ocup_d[cand] = 1'b1;
                    k_d          = k_q + 3'd1;
                    // k_q is the index of the role just written; the last one is medico
                    estado_d     = (k_q == 3'(N_LOBOS + 1)) ? PRONTO : SORTEIA;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        bus.pronto        = (estado_q == PRONTO);
        bus.ocupado       = (estado_q == LIMPA) || (estado_q == SORTEIA) || (estado_q == VERIFICA);
        bus.classe_valida = bus.pronto && bus.mostra;
        bus.classe        = bus.classe_valida ? role_q[bus.jogador] : 2'b00;
        case (estado_q)
            OCIOSO, LIMPA, SORTEIA, VERIFICA, PRONTO: bus.db_estado = estado_q;
            default:                                  bus.db_estado = 3'b111;
        endcase
    end

endmodule

// File: tb/tb_sorteio_classes.sv
// Directed bench for sorteio_classes: reset state, latency, hand-derived tables, ignored starts, reset abort.
module tb_sorteio_classes;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   lat_cnt;

    sorteio_classes_if bus ();

    sorteio_classes #(.N_LOBOS(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Tables worked out by hand from the LFSR sequence of each seed.
    // 3C: 79(c1) F3(c3) E7(c7) CE(c6)            -> no rejection, 9 cycles
    // A5: 4A(c2) 95(c5) 2A(c2 rej) 54(c4) A9(c1) -> one rejection, 11 cycles
    localparam logic [1:0] TAB_3C [8] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd2};
    localparam logic [1:0] TAB_A5 [8] = '{2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        lat_cnt++;
    endtask

    task automatic start_draw(input logic [7:0] s);
        bus.seed   = s;
        bus.inicia = 1'b1;
        tick();
        bus.inicia = 1'b0;
        bus.seed   = 8'h00;
        lat_cnt    = 0;
        check_val("ocupado_after_start", {7'd0, bus.ocupado}, 8'd1);
    endtask

    task automatic wait_pronto(input string tag);
        while (!bus.pronto && lat_cnt < 600) tick();
        check_val(tag, {7'd0, bus.pronto}, 8'd1);
    endtask

    task automatic check_table(input string tag, input logic [1:0] exp [8]);
        int n_lobo, n_vid, n_med, n_ald;
        n_lobo = 0; n_vid = 0; n_med = 0; n_ald = 0;
        bus.mostra = 1'b1;
        for (int j = 0; j < 8; j++) begin
            bus.jogador = 3'(j);
            #1;
            check_val(tag, {6'd0, bus.classe}, {6'd0, exp[j]});
            case (bus.classe)
                2'b01:   n_lobo++;
                2'b10:   n_vid++;
                2'b11:   n_med++;
                default: n_ald++;
            endcase
        end
        check_val("classe_valida", {7'd0, bus.classe_valida}, 8'd1);
        check_val("count_lobo", 8'(n_lobo), 8'd2);
        check_val("count_vidente", 8'(n_vid), 8'd1);
        check_val("count_medico", 8'(n_med), 8'd1);
        check_val("count_aldeao", 8'(n_ald), 8'd4);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        lat_cnt     = 0;
        reset       = 1'b1;
        bus.inicia  = 1'b0;
        bus.seed    = 8'h00;
        bus.jogador = 3'd5;
        bus.mostra  = 1'b1;
        #12;
        check_val("rst_classe", {6'd0, bus.classe}, 8'd0);
        check_val("rst_valida", {7'd0, bus.classe_valida}, 8'd0);
        check_val("rst_pronto", {7'd0, bus.pronto}, 8'd0);
        check_val("rst_ocupado", {7'd0, bus.ocupado}, 8'd0);
        check_val("rst_estado", {5'd0, bus.db_estado}, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        check_val("idle_estado", {5'd0, bus.db_estado}, 8'd0);
        check_val("idle_classe", {6'd0, bus.classe}, 8'd0);

        // Seed 3C: exact latency and table.
        bus.mostra = 1'b0;
        start_draw(8'h3C);
        check_val("estado_limpa", {5'd0, bus.db_estado}, 8'd1);
        while (!bus.pronto && lat_cnt < 8) tick();
        check_val("pronto_not_early", {7'd0, bus.pronto}, 8'd0);
        wait_pronto("pronto_3c");
        check_val("latency_3c", 8'(lat_cnt), 8'd9);
        check_val("estado_pronto", {5'd0, bus.db_estado}, 8'd4);
        check_val("ocupado_in_pronto", {7'd0, bus.ocupado}, 8'd0);
        check_table("tab_3c", TAB_3C);

        // Seed 0 falls back to A5; both must match the A5 table.
        start_draw(8'h00);
        wait_pronto("pronto_s00");
        check_val("latency_s00", 8'(lat_cnt), 8'd11);
        check_table("tab_s00", TAB_A5);
        start_draw(8'hA5);
        wait_pronto("pronto_a5");
        check_val("latency_a5", 8'(lat_cnt), 8'd11);
        check_table("tab_a5", TAB_A5);
        start_draw(8'h3C);
        wait_pronto("pronto_3c_rep");
        check_table("tab_3c_rep", TAB_3C);

        // A second start during the draw must be ignored.
        start_draw(8'h3C);
        tick();
        bus.seed   = 8'h77;
        bus.inicia = 1'b1;
        tick();
        bus.inicia = 1'b0;
        bus.seed   = 8'h00;
        check_val("ignored_busy", {7'd0, bus.ocupado}, 8'd1);
        wait_pronto("pronto_ignored");
        check_val("latency_ignored", 8'(lat_cnt), 8'd9);
        check_table("tab_ignored", TAB_3C);

        // In PRONTO: mostra low hides the table; a restart drops pronto.
        bus.mostra  = 1'b0;
        bus.jogador = 3'd6;
        #1;
        check_val("mostra_off_classe", {6'd0, bus.classe}, 8'd0);
        check_val("mostra_off_valida", {7'd0, bus.classe_valida}, 8'd0);
        start_draw(8'hA5);
        check_val("restart_pronto", {7'd0, bus.pronto}, 8'd0);
        wait_pronto("pronto_restart");
        check_table("tab_restart", TAB_A5);

        // Reset while in VERIFICA aborts immediately.
        bus.mostra = 1'b0;
        start_draw(8'h3C);
        tick();
        tick();
        check_val("estado_verifica", {5'd0, bus.db_estado}, 8'd3);
        reset = 1'b1;
        #1;
        check_val("abort_estado", {5'd0, bus.db_estado}, 8'd0);
        check_val("abort_ocupado", {7'd0, bus.ocupado}, 8'd0);
        check_val("abort_pronto", {7'd0, bus.pronto}, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        check_val("abort_idle", {5'd0, bus.db_estado}, 8'd0);
        start_draw(8'h3C);
        wait_pronto("pronto_after_abort");
        check_val("latency_after_abort", 8'(lat_cnt), 8'd9);
        check_table("tab_after_abort", TAB_3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
